// File: rtl/frame_color_stat_pkg.sv
// Shared definitions for the frame colour statistics block: colour codes,
// FSM state encoding, default frame/threshold sizes and the dominance rule.
package frame_color_stat_pkg;

  localparam int CW       = 15;
  localparam int DEF_NPIX = 19200;
  localparam int DEF_THR  = 4800;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    RED   = 2'd1,
    GREEN = 2'd2,
    BLUE  = 2'd3
  } color_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC    = 2'd1,
    DECIDE = 2'd2
  } state_e;

  // A colour wins only with a strictly largest count that also reaches thr;
  // any tie for the maximum yields NONE.
  function automatic color_e pick_color(input logic [CW-1:0] r,
                                        input logic [CW-1:0] g,
                                        input logic [CW-1:0] b,
                                        input logic [CW-1:0] thr);
    pick_color = NONE;
    if (r > g && r > b && r >= thr)      pick_color = RED;
    else if (g > r && g > b && g >= thr) pick_color = GREEN;
    else if (b > r && b > g && b >= thr) pick_color = BLUE;
  endfunction

endpackage

// File: rtl/frame_color_stat_px_classify.sv
// Combinational RGB332 pixel classifier: a channel wins when it exceeds both
// other channels by at least 2 on a common 3-bit scale.
module px_classify
  import frame_color_stat_pkg::*;
(
  input  logic [7:0] px,
  output color_e     cls
);

  logic [3:0] r4;
  logic [3:0] g4;
  logic [3:0] b4;

  // Blue has 2 bits; replicating its MSB stretches it onto the 0..7 scale.
  // The extra leading zero keeps the +2 from wrapping.
  always_comb begin
    r4  = {1'b0, px[7:5]};
    g4  = {1'b0, px[4:2]};
    b4  = {1'b0, px[1:0], px[1]};
    cls = NONE;
    if (r4 >= g4 + 4'd2 && r4 >= b4 + 4'd2)      cls = RED;
    else if (g4 >= r4 + 4'd2 && g4 >= b4 + 4'd2) cls = GREEN;
    else if (b4 >= r4 + 4'd2 && b4 >= g4 + 4'd2) cls = BLUE;
  end

endmodule

// File: rtl/frame_color_stat.sv
// Per-frame colour statistics: counts red/green/blue pixels over a frame that
// starts at address 1 and spans NPIX pixels, then reports the dominant colour.
module frame_color_stat
  import frame_color_stat_pkg::*;
#(
  parameter int AW   = 15,
  parameter int NPIX = DEF_NPIX,
  parameter int THR  = DEF_THR
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          px_wr,
  input  logic [AW-1:0] mem_px_addr,
  input  logic [7:0]    mem_px_data,
  output logic [1:0]    color,
  output logic          result_valid,
  output logic [CW-1:0] red_cnt,
  output logic [CW-1:0] green_cnt,
  output logic [CW-1:0] blue_cnt,
  output logic          frame_err
);

  localparam logic [CW-1:0] NPIX_C = CW'(NPIX);
  localparam logic [CW-1:0] THR_C  = CW'(THR);
  // A one-pixel frame is complete as soon as its first pixel is taken.
  localparam state_e START_NEXT = (NPIX_C == CW'(1)) ? DECIDE : ACC;

  color_e        px_cls;
  state_e        state;
  logic [CW-1:0] pix_cnt;
  logic [CW-1:0] r_acc;
  logic [CW-1:0] g_acc;
  logic [CW-1:0] b_acc;
  logic [CW-1:0] is_r;
  logic [CW-1:0] is_g;
  logic [CW-1:0] is_b;
  logic          start_px;

  px_classify u_classify (
    .px  (mem_px_data),
    .cls (px_cls)
  );

  assign is_r     = CW'(px_cls == RED);
  assign is_g     = CW'(px_cls == GREEN);
  assign is_b     = CW'(px_cls == BLUE);
  assign start_px = px_wr && (mem_px_addr == AW'(1));

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      pix_cnt      <= '0;
      r_acc        <= '0;
      g_acc        <= '0;
      b_acc        <= '0;
      color        <= 2'd0;
      red_cnt      <= '0;
      green_cnt    <= '0;
      blue_cnt     <= '0;
      result_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      frame_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (start_px) begin
            pix_cnt <= CW'(1);
            r_acc   <= is_r;
            g_acc   <= is_g;
            b_acc   <= is_b;
            state   <= START_NEXT;
          end
        end
        ACC: begin
          // Address 1 mid-frame means the source restarted: flag and resync.
          if (start_px && pix_cnt < NPIX_C) begin
            frame_err <= 1'b1;
            pix_cnt   <= CW'(1);
            r_acc     <= is_r;
            g_acc     <= is_g;
            b_acc     <= is_b;
            state     <= START_NEXT;
          end else if (px_wr) begin
            pix_cnt <= pix_cnt + CW'(1);
            r_acc   <= r_acc + is_r;
            g_acc   <= g_acc + is_g;
            b_acc   <= b_acc + is_b;
            if (pix_cnt + CW'(1) == NPIX_C) state <= DECIDE;
          end
        end
        DECIDE: begin
          red_cnt      <= r_acc;
          green_cnt    <= g_acc;
          blue_cnt     <= b_acc;
          color        <= pick_color(r_acc, g_acc, b_acc, THR_C);
          result_valid <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_color_stat.sv
// Self-checking bench for frame_color_stat with a 16-pixel frame and THR=4:
// table frames, directed corner sequences and randomized frames vs a model.
module tb_frame_color_stat;

  localparam int AW   = 15;
  localparam int NPIX = 16;
  localparam int THR  = 4;

  logic          pclk = 1'b0;
  logic          rst  = 1'b0;
  logic          px_wr = 1'b0;
  logic [AW-1:0] mem_px_addr = '0;
  logic [7:0]    mem_px_data = '0;
  logic [1:0]    color;
  logic          result_valid;
  logic [14:0]   red_cnt;
  logic [14:0]   green_cnt;
  logic [14:0]   blue_cnt;
  logic          frame_err;

  frame_color_stat #(.AW(AW), .NPIX(NPIX), .THR(THR)) dut (
    .pclk         (pclk),
    .rst          (rst),
    .px_wr        (px_wr),
    .mem_px_addr  (mem_px_addr),
    .mem_px_data  (mem_px_data),
    .color        (color),
    .result_valid (result_valid),
    .red_cnt      (red_cnt),
    .green_cnt    (green_cnt),
    .blue_cnt     (blue_cnt),
    .frame_err    (frame_err)
  );

  always #5 pclk = ~pclk;

  int total = 0;
  int bad   = 0;
  int errs_seen = 0;
  int errs_exp  = 0;
  logic [46:0] exp_q[$];
  logic [46:0] last_exp = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every result pulse must match the oldest expected frame.
  always @(negedge pclk) begin
    if (rst && frame_err) errs_seen++;
    if (rst && result_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 64'(result_valid), 64'(0));
      end else begin
        check("frame_result", 64'({color, red_cnt, green_cnt, blue_cnt}), 64'(exp_q.pop_front()));
      end
    end
  end

  // Reference model: classify on the 0..7 scale using plain integer arithmetic.
  function automatic int ref_cls(input logic [7:0] p);
    int r, g, b;
    r = int'(p[7:5]);
    g = int'(p[4:2]);
    b = int'(p[1:0]) * 2 + int'(p[1]);
    if (r - g >= 2 && r - b >= 2) return 1;
    if (g - r >= 2 && g - b >= 2) return 2;
    if (b - r >= 2 && b - g >= 2) return 3;
    return 0;
  endfunction

  function automatic logic [46:0] ref_frame(input logic [7:0] px[NPIX]);
    int cnt[4];
    int m, n, col;
    cnt = '{0, 0, 0, 0};
    foreach (px[i]) cnt[ref_cls(px[i])]++;
    m = cnt[1];
    if (cnt[2] > m) m = cnt[2];
    if (cnt[3] > m) m = cnt[3];
    n = 0;
    col = 0;
    for (int c = 1; c <= 3; c++) if (cnt[c] == m) begin n++; col = c; end
    if (n != 1 || m < THR) col = 0;
    return {2'(col), 15'(cnt[1]), 15'(cnt[2]), 15'(cnt[3])};
  endfunction

  task automatic send_px(input int addr, input logic [7:0] data);
    px_wr       = 1'b1;
    mem_px_addr = AW'(addr);
    mem_px_data = data;
    @(negedge pclk);
    px_wr       = 1'b0;
    mem_px_data = 8'($urandom_range(0, 255));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      px_wr       = 1'b0;
      mem_px_addr = AW'(1);
      mem_px_data = 8'($urandom_range(0, 255));
      @(negedge pclk);
    end
  endtask

  task automatic send_frame(input logic [7:0] px[NPIX], input int max_gap);
    for (int i = 0; i < NPIX; i++) begin
      send_px(i + 1, px[i]);
      if (max_gap > 0 && i < NPIX - 1) idle($urandom_range(0, max_gap));
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge pclk);
      n++;
    end
    check("result_timeout", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
  endtask

  typedef struct {
    logic [7:0]  a;
    int          na;
    logic [7:0]  b;
    int          nb;
    logic [7:0]  c;
    logic [1:0]  col;
    logic [14:0] rc;
    logic [14:0] gc;
    logic [14:0] bc;
  } vec_t;

  vec_t tbl[6];
  logic [7:0] frm[NPIX];
  logic [7:0] palette[4];

  initial begin
    tbl[0] = '{8'hE0, 16, 8'h00, 0, 8'h00, 2'd1, 15'd16, 15'd0, 15'd0};
    tbl[1] = '{8'h1C, 6, 8'h03, 6, 8'hFF, 2'd0, 15'd0, 15'd6, 15'd6};
    tbl[2] = '{8'hE0, 3, 8'h92, 13, 8'h92, 2'd0, 15'd3, 15'd0, 15'd0};
    tbl[3] = '{8'hE0, 4, 8'h92, 12, 8'h92, 2'd1, 15'd4, 15'd0, 15'd0};
    tbl[4] = '{8'h1C, 5, 8'h03, 4, 8'hE0, 2'd1, 15'd7, 15'd5, 15'd4};
    tbl[5] = '{8'h03, 16, 8'h00, 0, 8'h00, 2'd3, 15'd0, 15'd0, 15'd16};
    palette = '{8'hE0, 8'h1C, 8'h03, 8'h92};

    // Reset state
    repeat (3) @(negedge pclk);
    check("reset_outputs", 64'({color, red_cnt, green_cnt, blue_cnt, result_valid, frame_err}), 64'(0));
    rst = 1'b1;
    idle(2);
    send_px(5, 8'hE0);
    idle(3);
    check("idle_ignores_non_start", 64'(result_valid), 64'(0));

    // All-red frame with exact result latency
    last_exp = {2'd1, 15'd16, 15'd0, 15'd0};
    exp_q.push_back(last_exp);
    for (int i = 1; i <= NPIX; i++) send_px(i, 8'hE0);
    check("result_not_early", 64'(result_valid), 64'(0));
    @(negedge pclk);
    check("result_latency", 64'(result_valid), 64'(1));
    @(negedge pclk);
    check("result_one_cycle", 64'(result_valid), 64'(0));
    idle(3);
    check("outputs_hold", 64'({color, red_cnt, green_cnt, blue_cnt}), 64'(last_exp));
    wait_done();

    // Table frames
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < NPIX; i++)
        frm[i] = (i < tbl[t].na) ? tbl[t].a : (i < tbl[t].na + tbl[t].nb) ? tbl[t].b : tbl[t].c;
      last_exp = {tbl[t].col, tbl[t].rc, tbl[t].gc, tbl[t].bc};
      exp_q.push_back(last_exp);
      send_frame(frm, t % 3);
      wait_done();
      idle(2);
    end

    // Short frame restarted at address 1
    for (int i = 1; i <= 5; i++) send_px(i, 8'h1C);
    send_px(1, 8'h03);
    errs_exp++;
    check("frame_err_pulse", 64'(frame_err), 64'(1));
    check("restart_keeps_outputs", 64'({color, red_cnt, green_cnt, blue_cnt}), 64'(last_exp));
    last_exp = {2'd3, 15'd0, 15'd0, 15'd16};
    exp_q.push_back(last_exp);
    for (int i = 2; i <= NPIX; i++) send_px(i, 8'h03);
    check("frame_err_one_cycle", 64'(frame_err), 64'(0));
    wait_done();
    idle(2);

    // Reset mid-frame, then a clean green frame
    for (int i = 1; i <= 8; i++) send_px(i, 8'hE0);
    rst = 1'b0;
    #1;
    check("async_reset_outputs", 64'({color, red_cnt, green_cnt, blue_cnt}), 64'(0));
    @(negedge pclk);
    rst = 1'b1;
    idle(2);
    last_exp = {2'd2, 15'd0, 15'd16, 15'd0};
    exp_q.push_back(last_exp);
    for (int i = 1; i <= NPIX; i++) send_px(i, 8'h1C);
    // This pixel lands in the DECIDE cycle and must not start or join a frame.
    send_px(1, 8'hE0);
    wait_done();
    last_exp = {2'd3, 15'd0, 15'd0, 15'd16};
    exp_q.push_back(last_exp);
    for (int i = 1; i <= NPIX; i++) send_px(i, 8'h03);
    wait_done();
    check("no_err_after_decide_px", 64'(errs_seen), 64'(errs_exp));
    idle(2);

    // Randomized frames against the reference model
    for (int f = 0; f < 25; f++) begin
      for (int i = 0; i < NPIX; i++)
        frm[i] = $urandom_range(0, 1) ? palette[$urandom_range(0, 3)] : 8'($urandom_range(0, 255));
      send_px($urandom_range(2, NPIX), 8'($urandom_range(0, 255)));
      idle($urandom_range(0, 2));
      last_exp = ref_frame(frm);
      exp_q.push_back(last_exp);
      send_frame(frm, 2);
      wait_done();
      idle($urandom_range(1, 3));
      check("rand_hold", 64'({color, red_cnt, green_cnt, blue_cnt}), 64'(last_exp));
    end

    check("frame_err_total", 64'(errs_seen), 64'(errs_exp));
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_color_stat.md
FRAME_COLOR_STAT -- requirements
Module: frame_color_stat

Interface
REQ-001 The block SHALL have parameter AW, default 15: width of the pixel address.
REQ-002 The block SHALL have parameter NPIX, default 19200: number of pixels per frame (160x120).
REQ-003 The block SHALL have parameter THR, default 4800: minimum pixel count for a colour to be declared dominant.
REQ-004 The block SHALL have port pclk, input, 1 bit: the single clock; all logic is rising-edge triggered.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port px_wr, input, 1 bit: one pixel is valid on each cycle where px_wr is high.
REQ-007 The block SHALL have port mem_px_addr, input, AW bits: the frame-buffer address of the pixel.
REQ-008 The block SHALL have port mem_px_data, input, 8 bits: the RGB332 pixel (R=[7:5], G=[4:2], B=[1:0]).
REQ-009 The block SHALL have port color, output, 2 bits: dominant colour of the last frame (0 none, 1 red, 2 green, 3 blue).
REQ-010 The block SHALL have port result_valid, output, 1 bit: one-cycle pulse that accompanies a new colour and counts.
REQ-011 The block SHALL have ports red_cnt, green_cnt and blue_cnt, output, 15 bits each: per-frame class counts of the last completed frame.
REQ-012 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse when a frame restarts before NPIX pixels were received.

Function
REQ-013 Classification SHALL be combinational per pixel:
- R3=R, G3=G, B3={B,B[1]}.
- Red if R3 >= G3+2 and R3 >= B3+2; green and blue are defined the same way.
- Otherwise the pixel is "other" and is not counted.
- Comparisons SHALL use 4-bit arithmetic so that +2 cannot overflow.
REQ-014 FSM states SHALL be IDLE, ACC and DECIDE.
REQ-015 In IDLE, px_wr with mem_px_addr==1 SHALL start a frame:
- pix_cnt:=1 and the class counters are loaded with that pixel's class.
- The FSM moves to ACC.
- Other px_wr cycles in IDLE SHALL be ignored.
REQ-016 In ACC, each px_wr SHALL increment pix_cnt and the matching class counter, all at the same edge.
REQ-017 When pix_cnt reaches NPIX at an edge (the edge that samples the last pixel), the FSM SHALL move to DECIDE.
REQ-018 DECIDE SHALL last exactly one cycle. At its closing edge the block SHALL:
- copy the counters to red_cnt, green_cnt and blue_cnt;
- set color to the class with the strictly largest count, provided that count >= THR, else 0;
- treat any tie for the maximum as 0;
- pulse result_valid for one cycle;
- return the FSM to IDLE.
REQ-019 Latency: result_valid SHALL be high in the second cycle after the edge that samples the NPIXth pixel.
REQ-020 px_wr during DECIDE SHALL be ignored and SHALL not be counted.
REQ-021 In ACC, px_wr with mem_px_addr==1 and pix_cnt<NPIX SHALL:
- pulse frame_err for one cycle;
- reload the counters as in REQ-015 and stay in ACC;
- leave color and the *_cnt outputs unchanged.
REQ-022 color and the *_cnt outputs SHALL hold their values between result_valid pulses.
REQ-023 Internal counters SHALL be 15 bits; NPIX <= 32767 is a parameter constraint, and counters SHALL never wrap within a frame.

Reset
REQ-024 rst low SHALL asynchronously force:
- state to IDLE;
- pix_cnt and all class counters to 0;
- color=0, red_cnt=green_cnt=blue_cnt=0, result_valid=0 and frame_err=0.
REQ-025 Reset asserted mid-frame SHALL discard the partial frame; after release the block waits for the next addr==1 pixel.

Structure
REQ-026 A shared package SHALL hold:
- the colour codes (NONE, RED, GREEN, BLUE);
- the FSM state encoding;
- the default NPIX and THR constants.
REQ-027 Pixel classification SHALL be one combinational sub-module, px_classify (8-bit in, 2-bit class out).

Verification
REQ-028 The bench SHALL use NPIX=16 and THR=4, and SHALL cover these directed scenarios:
- 16 pixels 0xE0 (red), addr 1..16 -> red_cnt=16, green_cnt=0, blue_cnt=0, color=1, result_valid high 2 cycles after the 16th px_wr.
- 6 pixels 0x1C (green) + 6 pixels 0x03 (blue) + 4 pixels 0xFF -> counts 0/6/6, color=0 (tie).
- 3 pixels 0xE0 + 13 pixels 0x92 (grey) -> red_cnt=3 < THR -> color=0, result_valid=1.
- 5 pixels, then px_wr at addr 1 -> frame_err pulse; the following 16-pixel blue frame -> blue_cnt=16, color=3.
- rst low after 8 pixels, then a full green frame -> green_cnt=16, color=2, no frame_err; px_wr during DECIDE is not counted in the next frame.
